// File: rtl/falafel_pkg.sv
// ---------------------------------------------------------------------------
// falafel_pkg
// Shared types for the falafel allocator datapath: LSU operation codes, the
// machine word, the free-list block descriptor and the LSU arbiter FSM state.
// ---------------------------------------------------------------------------
package falafel_pkg;

  typedef logic [31:0] word_t;

  // Free-list block descriptor as stored in memory.
  typedef struct packed {
    word_t next;
    word_t size;
  } free_block_t;

  // Operation encoding 0 is the idle/default value driven on unused buses.
  typedef enum logic [2:0] {
    LSU_READ        = 3'd0,
    LSU_WRITE       = 3'd1,
    LSU_LOCK        = 3'd2,
    LSU_UNLOCK      = 3'd3,
    LSU_READ_BLOCK  = 3'd4,
    LSU_WRITE_BLOCK = 3'd5
  } lsu_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GRANT    = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/falafel_rr_picker.sv
// ---------------------------------------------------------------------------
// falafel_rr_picker
// Combinational round-robin selector: returns the first set bit of valid at
// or after prio, wrapping modulo NUM_REQ.
//   valid  in  NUM_REQ  request bitmap
//   prio   in  IDX_W    highest-priority index
//   idx    out IDX_W    selected index (0 when nothing is valid)
//   any    out 1        at least one bit of valid is set
// ---------------------------------------------------------------------------
module falafel_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   prio,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  function automatic int rot_idx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
  endfunction

  // Scan from the farthest offset down to 0 so the nearest valid index,
  // written last, is the one that sticks.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    idx = '0;
    any = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (valid[rot_idx(int'(prio), off)]) begin
        idx = IDX_W'(rot_idx(int'(prio), off));
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// falafel_lsu_arbiter
// Round-robin arbiter sharing one falafel_lsu between NUM_REQ requesters.
// One transaction is in flight at a time; the grant is held from request
// acceptance until the response is consumed. A requester that raises
// req_hold_i at its response handshake keeps the grant for its next request,
// so lock / read-modify-write / unlock sequences stay atomic.
//
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   req_val_i / req_rdy_o     per-requester request handshake
//   req_op_i, req_addr_i, req_word_i, req_lock_id_i, req_block_i
//                             per-requester request fields
//   req_hold_i                keep the grant after this response
//   rsp_val_o / rsp_rdy_i     per-requester response handshake
//   rsp_word_o, rsp_block_o   response data, broadcast
//   lsu_req_*                 forwarded request to the LSU
//   lsu_rsp_*                 response from the LSU
// All outputs are decoded from the FSM state, so every output is 0 in reset.
// ---------------------------------------------------------------------------
module falafel_lsu_arbiter
  import falafel_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,

  input  logic [NUM_REQ-1:0] req_val_i,
  output logic [NUM_REQ-1:0] req_rdy_o,
  input  lsu_op_e            req_op_i      [NUM_REQ],
  input  word_t              req_addr_i    [NUM_REQ],
  input  word_t              req_word_i    [NUM_REQ],
  input  word_t              req_lock_id_i [NUM_REQ],
  input  free_block_t        req_block_i   [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_hold_i,

  output logic [NUM_REQ-1:0] rsp_val_o,
  input  logic [NUM_REQ-1:0] rsp_rdy_i,
  output word_t              rsp_word_o,
  output free_block_t        rsp_block_o,

  output logic               lsu_req_val_o,
  input  logic               lsu_req_rdy_i,
  output lsu_op_e            lsu_req_op_o,
  output word_t              lsu_req_addr_o,
  output word_t              lsu_req_word_o,
  output word_t              lsu_req_lock_id_o,
  output free_block_t        lsu_req_block_o,

  input  logic               lsu_rsp_val_i,
  output logic               lsu_rsp_rdy_o,
  input  word_t              lsu_rsp_word_i,
  input  free_block_t        lsu_rsp_block_i
);

  arb_state_e       state_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] prio_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] prio_next;
  logic             req_fire;
  logic             rsp_fire;

  falafel_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (req_val_i),
    .prio  (prio_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Priority moves to the requester just after the one that was served.
  assign prio_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  assign req_fire = (state_q == ARB_GRANT)    && req_val_i[grant_q] && lsu_req_rdy_i;
  assign rsp_fire = (state_q == ARB_WAIT_RSP) && lsu_rsp_val_i      && rsp_rdy_i[grant_q];

  // Output steering: only the granted requester is connected to the LSU, and
  // only in the phase matching the handshake in progress.
  always_comb begin
    req_rdy_o         = '0;
    rsp_val_o         = '0;
    rsp_word_o        = '0;
    rsp_block_o       = '0;
    lsu_req_val_o     = 1'b0;
    lsu_req_op_o      = LSU_READ;
    lsu_req_addr_o    = '0;
    lsu_req_word_o    = '0;
    lsu_req_lock_id_o = '0;
    lsu_req_block_o   = '0;
    lsu_rsp_rdy_o     = 1'b0;

    case (state_q)
      ARB_GRANT: begin
        lsu_req_val_o      = req_val_i[grant_q];
        lsu_req_op_o       = req_op_i[grant_q];
        lsu_req_addr_o     = req_addr_i[grant_q];
        lsu_req_word_o     = req_word_i[grant_q];
        lsu_req_lock_id_o  = req_lock_id_i[grant_q];
        lsu_req_block_o    = req_block_i[grant_q];
        req_rdy_o[grant_q] = lsu_req_rdy_i;
      end
      ARB_WAIT_RSP: begin
        rsp_val_o[grant_q] = lsu_rsp_val_i;
        lsu_rsp_rdy_o      = rsp_rdy_i[grant_q];
        rsp_word_o         = lsu_rsp_word_i;
        rsp_block_o        = lsu_rsp_block_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            state_q <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // A requester dropping valid here simply leaves us waiting.
          if (req_fire) state_q <= ARB_WAIT_RSP;
        end
        ARB_WAIT_RSP: begin
          if (rsp_fire) begin
            if (req_hold_i[grant_q]) begin
              state_q <= ARB_GRANT;
            end else begin
              prio_q  <= prio_next;
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/falafel_lsu_arbiter.md
# falafel_lsu_arbiter

Round-robin arbiter that shares one `falafel_lsu` between `NUM_REQ` requesters, such as the allocate and free engines. It accepts one LSU request at a time and forwards it to the LSU. It holds the grant until the matching response has been handed back. An optional per-requester hold keeps the grant across back-to-back operations, which allows atomic lock / read-modify-write / unlock sequences.

## Interface
- `NUM_REQ`, default 2. Number of requesters; must be 2 or more.
- `IDX_W`, default `$clog2(NUM_REQ)`. Width of the grant index; derived, not overridden.

Ports (`[N]` = `NUM_REQ`-wide array):
- `clk_i`  in  1  Single clock.
- `rst_ni`  in  1  Reset: asynchronous, active-low.
- `req_val_i[N]`  in  1  Requester request valid.
- `req_rdy_o[N]`  out  1  Request accepted.
- `req_op_i[N]`  in  `lsu_op_e`  LSU operation.
- `req_addr_i[N]`, `req_word_i[N]`, `req_lock_id_i[N]`  in  `word_t`  Request fields.
- `req_block_i[N]`  in  `free_block_t`  Block to write.
- `req_hold_i[N]`  in  1  Keep the grant after this transaction's response.
- `rsp_val_o[N]`  out  1  Response valid; only the granted requester's bit can be set.
- `rsp_rdy_i[N]`  in  1  Requester accepts response.
- `rsp_word_o`  out  `word_t`  Response word, broadcast to all requesters.
- `rsp_block_o`  out  `free_block_t`  Response block, broadcast to all requesters.
- `lsu_req_val_o`  out  1  Request valid to the LSU.
- `lsu_req_rdy_i`  in  1  LSU ready for a request.
- `lsu_req_op_o`, `lsu_req_addr_o`, `lsu_req_word_o`, `lsu_req_lock_id_o`, `lsu_req_block_o`  out  Same types as the request fields; forwarded request.
- `lsu_rsp_val_i`  in  1  LSU response valid.
- `lsu_rsp_rdy_o`  out  1  Arbiter accepts the LSU response.
- `lsu_rsp_word_i`  in  `word_t`  LSU response word.
- `lsu_rsp_block_i`  in  `free_block_t`  LSU response block.

## Operation
- State machine states: `ARB_IDLE`, `ARB_GRANT`, `ARB_WAIT_RSP`.
- Registers:
  - `grant_q` (`IDX_W` bits): current grant index.
  - `prio_q` (`IDX_W` bits): highest-priority index for the next pick.
- `ARB_IDLE`:
  - If any `req_val_i` is set, pick the first set index at or after `prio_q`, wrapping modulo `NUM_REQ`.
  - Load `grant_q` with it and go to `ARB_GRANT`.
- `ARB_GRANT`:
  - All `lsu_req_*` outputs are combinational copies of requester `grant_q`.
  - `lsu_req_val_o = req_val_i[grant_q]`.
  - `req_rdy_o[grant_q] = lsu_req_rdy_i`; all other bits of `req_rdy_o` are 0.
  - On the handshake (`val && rdy`), go to `ARB_WAIT_RSP`.
- `ARB_WAIT_RSP`:
  - `rsp_val_o[grant_q] = lsu_rsp_val_i`.
  - `lsu_rsp_rdy_o = rsp_rdy_i[grant_q]`.
  - `rsp_word_o` / `rsp_block_o` pass through from the LSU.
  - On the response handshake:
    - If `req_hold_i[grant_q]` is set, go to `ARB_GRANT` with `grant_q` unchanged.
    - Otherwise set `prio_q` to `grant_q+1` (wrapping at `NUM_REQ-1` to 0) and go to `ARB_IDLE`.
- Outside `ARB_GRANT`: `lsu_req_val_o` and all `req_rdy_o` bits are 0, and the `lsu_req_*` data outputs are 0.
- Outside `ARB_WAIT_RSP`: `rsp_val_o`, `lsu_rsp_rdy_o`, `rsp_word_o` and `rsp_block_o` are 0.
- `req_hold_i` is sampled only at the response handshake.
- A held requester with no new request keeps the grant indefinitely. Starvation of other requesters is intentional; software bounds hold sequences.

## Timing
- Reset values:
  - State is `ARB_IDLE`; `grant_q` and `prio_q` are 0.
  - Every output is 0.
- Reset is asynchronous and can assert at any point, including mid-transaction. The outstanding LSU transaction is abandoned, so the LSU must be reset together with the arbiter.
- Arbitration latency: `req_val_i` rising in `ARB_IDLE` gives `lsu_req_val_o` high on the next cycle. With the LSU ready, the earliest request handshake is 1 cycle after `req_val_i`.
- Held re-grant: a new request can handshake on the cycle after the response handshake, with no arbitration cycle.
- Requester protocol:
  - `req_val_i` and the request fields must stay stable until `req_rdy_o`.
  - Dropping `req_val_i` while in `ARB_GRANT` is a protocol violation; the arbiter stays in `ARB_GRANT`.
- Simultaneous requests in `ARB_IDLE`: only the winner sees `req_rdy_o`. The others wait with `req_rdy_o = 0`.
- A request arriving while the arbiter is busy is considered at the next `ARB_IDLE` cycle.

## Structure
- `falafel_pkg` gains `arb_state_e` (`ARB_IDLE`, `ARB_GRANT`, `ARB_WAIT_RSP`). It reuses the existing `lsu_op_e`, `word_t` and `free_block_t`.
- Sub-module `falafel_rr_picker`: purely combinational. Inputs are `valid[N]` and `prio`; outputs are `idx` and `any`.

## Test plan
- `NUM_REQ=2`, only requester 1 requests `addr=0x40`: `lsu_req_val_o` rises 1 cycle later with addr 0x40. LSU response word 0x1234 → `rsp_val_o=2'b10`, `rsp_word_o=0x1234`, then `ARB_IDLE` with `prio_q=0`.
- Both requesters hold `val` for 4 transactions: grants alternate 0,1,0,1, and each requester sees `req_rdy_o` only on its own turn.
- Requester 0 with `req_hold_i=1` for 3 ops, then 0, while requester 1 waits: requester 0 gets 3 back-to-back ops with no idle cycle, then requester 1 is granted.
- LSU stalls `lsu_req_rdy_i=0` for 5 cycles and `rsp_rdy_i=0` for 3 cycles: request fields are stable, no double handshake, and response data is held.
- `rst_ni` asserted in `ARB_WAIT_RSP`: all outputs are 0 immediately, and after release state is `ARB_IDLE` with `prio_q=0`.
- `NUM_REQ=3`, `prio_q=2` with requests from 0 and 1: requester 0 wins (wrap-around).
